axis_passthrough: RTL and testbench

Single-clock AXI4-Stream passthrough with an internal first-word-fall-through FIFO. Sits between an AXI-Stream pixel/image source and downstream CNN processing stages. Forwards every beat unmodified: tdata, tstrb, tlast and tuser are preserved, and beat order is preserved. The FIFO decouples source and sink back-pressure.

---
 rtl/axis_passthrough_pkg.sv | 27 ++
 rtl/axis_passthrough_fifo.sv | 87 ++++++++
 rtl/axis_passthrough.sv | 81 ++++++++
 tb/tb_axis_passthrough.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_passthrough_pkg.sv
// axis_passthrough_pkg
//   Shared types and sizing helpers for the AXI4-Stream passthrough.
//   beat_t is the beat record at the default 32-bit data width; the FIFO
//   itself stores a flat vector so other widths work through parameters.
package axis_passthrough_pkg;

    localparam int unsigned TDATA_WIDTH = 32;
    localparam int unsigned TSTRB_WIDTH = TDATA_WIDTH / 8;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [TSTRB_WIDTH-1:0] strb;
        logic                   last;
        logic                   user;
    } beat_t;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_passthrough_fifo.sv
// axis_passthrough_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is held in a
//   register (dout) so it keeps its last value when the FIFO runs empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write strobe and entry
//   pop           read strobe (advance past the head)
//   dout          head entry
//   full, empty   occupancy flags
//   level         occupancy count (only with AXIS_PASSTHROUGH_LEVEL_EN)
module axis_passthrough_fifo
    import axis_passthrough_pkg::*;
#(
    parameter  int unsigned WIDTH = 38,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
    ,
    output logic [CW-1:0]    level
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;

    always_comb begin
        rd_next = rd_ptr + AW'(pop);
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        // Preload the next head: if nothing older survives this edge, the
        // entry being written now becomes the head (one-cycle latency).
        head_next = dout;
        if (count_next != '0) begin
            if ((count - CW'(pop)) == '0) begin
                head_next = din;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_next;
            count  <= count_next;
            dout   <= head_next;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef AXIS_PASSTHROUGH_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: rtl/axis_passthrough.sv
// axis_passthrough
//   AXI4-Stream passthrough with an internal FWFT FIFO. Beats
//   {tdata, tstrb, tlast, tuser} are forwarded unmodified and in order.
//   Optional macro AXIS_PASSTHROUGH_LEVEL_EN adds the fifo_level output.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s00_axis_*          input stream (tready = !full, registered state only)
//   m00_axis_*          output stream (tvalid = !empty, fields = FIFO head)
//   fifo_level          occupancy count (only with AXIS_PASSTHROUGH_LEVEL_EN)
module axis_passthrough
    import axis_passthrough_pkg::*;
#(
    parameter  int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter  int unsigned C_AXIS_FIFO_DEPTH  = 16,
    localparam int unsigned STRB_W             = strb_width(C_AXIS_TDATA_WIDTH),
    localparam int unsigned CNT_W              = count_width(C_AXIS_FIFO_DEPTH),
    localparam int unsigned BEAT_W             = C_AXIS_TDATA_WIDTH + STRB_W + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [STRB_W-1:0]             s00_axis_tstrb,
    input  logic                          s00_axis_tlast,
    input  logic                          s00_axis_tuser,
    output logic                          m00_axis_tvalid,
    input  logic                          m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [STRB_W-1:0]             m00_axis_tstrb,
    output logic                          m00_axis_tlast,
    output logic                          m00_axis_tuser
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
    ,
    output logic [CNT_W-1:0]              fifo_level
`endif
);

    logic              out_of_reset;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [BEAT_W-1:0] head;

    // Keeps tready low while reset is held; the FIFO count alone would
    // already report not-full during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    assign s00_axis_tready = out_of_reset && !full;
    assign m00_axis_tvalid = !empty;
    assign push            = s00_axis_tvalid && s00_axis_tready;
    assign pop             = m00_axis_tvalid && m00_axis_tready;

    axis_passthrough_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (C_AXIS_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .din   ({s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tuser}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
        ,
        .level (fifo_level)
`endif
    );

    assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tuser} = head;

endmodule

// File: tb/tb_axis_passthrough.sv
module tb_axis_passthrough;
    import axis_passthrough_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [3:0]  s_strb = '0;
    logic        s_last = 1'b0;
    logic        s_user = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        m_last;
    logic        m_user;
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
    logic [4:0]  level;
`endif

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int popped   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    axis_passthrough #(
        .C_AXIS_TDATA_WIDTH (32),
        .C_AXIS_FIFO_DEPTH  (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s00_axis_tvalid (s_valid),
        .s00_axis_tready (s_ready),
        .s00_axis_tdata  (s_data),
        .s00_axis_tstrb  (s_strb),
        .s00_axis_tlast  (s_last),
        .s00_axis_tuser  (s_user),
        .m00_axis_tvalid (m_valid),
        .m00_axis_tready (m_ready),
        .m00_axis_tdata  (m_data),
        .m00_axis_tstrb  (m_strb),
        .m00_axis_tlast  (m_last),
        .m00_axis_tuser  (m_user)
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
        ,
        .fifo_level      (level)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] st,
                                 input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.strb = st;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    task automatic check_level(input string tag, input int exp);
`ifdef AXIS_PASSTHROUGH_LEVEL_EN
        check(tag, 64'(level), 64'(exp));
`else
        check(tag, 64'(exp == 0), 64'(!m_valid));
`endif
    endtask

    // Scores the handshakes that the coming edge performs, then advances
    // to 1 time unit after that edge.
    task automatic cycle();
        beat_t b;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(1), 64'(0));
            end else begin
                b = exp_q.pop_front();
                check("beat", 64'({m_data, m_strb, m_last, m_user}), 64'(b));
            end
            popped++;
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(mk(s_data, s_strb, s_last, s_user));
            pushed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b);
        s_data = b.data;
        s_strb = b.strb;
        s_last = b.last;
        s_user = b.user;
    endtask

    task automatic send(input beat_t b);
        int t = 0;
        s_valid = 1'b1;
        drive(b);
        while (!s_ready && t < 200) begin
            cycle();
            t++;
        end
        if (t == 200) check("send_timeout", 64'(0), 64'(1));
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        m_ready = 1'b1;
        while (exp_q.size() > 0 && t < 100) begin
            cycle();
            t++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        check("drain_valid", 64'(m_valid), 64'(0));
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int sent;
        logic acc;

        // Reset values
        #1;
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_fields", 64'({m_data, m_strb, m_last, m_user}), 64'(0));
        check_level("rst_level", 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(s_ready), 64'(1));

        // Streaming with one-cycle latency
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(mk(32'(i + 1), 4'hF, i == 15, i == 0));
            check("stream_valid", 64'(m_valid), 64'(1));
            check("stream_data", 64'(m_data), 64'(i + 1));
        end
        cycle();
        check("stream_done_valid", 64'(m_valid), 64'(0));
        check("stream_count", 64'(popped), 64'(16));

        // Back-pressure fill of 20 beats
        m_ready = 1'b0;
        p0 = pushed;
        for (int i = 0; i < 16; i++) send(mk(32'h100 + 32'(i), 4'hF, 1'b0, i == 0));
        check("full_ready", 64'(s_ready), 64'(0));
        check_level("full_level", 16);
        s_valid = 1'b1;
        drive(mk(32'h110, 4'hF, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) cycle();
        check("full_no_push", 64'(pushed - p0), 64'(16));
        check("full_hold_data", 64'(m_data), 64'(32'h100));
        m_ready = 1'b1;
        for (int i = 16; i < 20; i++) send(mk(32'h100 + 32'(i), 4'hF, i == 19, 1'b0));
        drain();
        check("bp_pushed", 64'(pushed - p0), 64'(20));

        // Simultaneous push/pop at occupancy 8
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(mk(32'h200 + 32'(i), 4'h3, 1'b0, 1'b0));
        check_level("mid_level", 8);
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int j = 0; j < 100; j++) begin
            drive(mk(32'h200 + 32'(j + 8), 4'h3, 1'b0, 1'b0));
            check("delay8_data", 64'(m_data), 64'(32'h200 + 32'(j)));
            cycle();
        end
        s_valid = 1'b0;
        check_level("steady_level", 8);
        drain();

        // Wrap-around with random stalls on both sides
        p0 = popped;
        sent = 0;
        for (int t = 0; t < 1000 && (sent < 40 || exp_q.size() > 0); t++) begin
            if (!s_valid) s_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
            if (s_valid) begin
                case (sent % 3)
                    0:       drive(mk(32'h300 + 32'(sent), 4'hF, sent % 8 == 7, sent == 0));
                    1:       drive(mk(32'h300 + 32'(sent), 4'h3, sent % 8 == 7, 1'b0));
                    default: drive(mk(32'h300 + 32'(sent), 4'h1, sent % 8 == 7, 1'b0));
                endcase
            end
            m_ready = ($urandom_range(0, 2) != 0);
            acc = s_valid && s_ready;
            cycle();
            if (acc) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        check("wrap_sent", 64'(sent), 64'(40));
        check("wrap_popped", 64'(popped - p0), 64'(40));

        // Mid-stream reset
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(32'hA5A5_0001 + 32'(i), 4'hF, 1'b0, i == 0));
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("mrst_valid", 64'(m_valid), 64'(0));
        check("mrst_fields", 64'({m_data, m_strb, m_last, m_user}), 64'(0));
        check("mrst_ready", 64'(s_ready), 64'(0));
        check_level("mrst_level", 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(mk(32'hA5A5_0006, 4'hF, 1'b0, 1'b1));
        check("mrst_first_out", 64'(m_data), 64'(32'hA5A5_0006));
        drain();

        // Single beat then idle
        p0 = popped;
        send(mk(32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0));
        check("single_valid", 64'(m_valid), 64'(1));
        check("single_last", 64'(m_last), 64'(1));
        for (int i = 0; i < 6; i++) cycle();
        check("single_pops", 64'(popped - p0), 64'(1));
        check("single_idle", 64'(m_valid), 64'(0));
        check("single_hold", 64'(m_data), 64'(32'hDEAD_BEEF));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
